// File: rtl/test_pkg.sv
// test_pkg -- shared types for the test_checker slice.
//   state_e  : checker FSM states (IDLE -> RUN -> DONE, DONE held until reset).
//   result_t : sticky status flags reported by the checker.
package test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic done;
    logic all_pass;
    logic fail_valid;
    logic timeout;
  } result_t;

  localparam result_t RESULT_CLEAR = '{done: 1'b0, all_pass: 1'b0, fail_valid: 1'b0, timeout: 1'b0};

endpackage

// File: rtl/test_checker_if.sv
// test_checker_if -- bundle between a test harness and test_checker.
//   Table load : load_valid, load_idx, load_num_inst, load_ans
//   Run control: start
//   DUT probes : num_inst, output_port, is_halted
//   Results    : done, all_pass, pass_count, fail_valid, fail_idx, fail_got,
//                timeout, num_clock
//   master = harness side (drives load/start/probes), slave = checker side.
interface test_checker_if #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 16
);

  logic                 load_valid;
  logic [IDX_W-1:0]     load_idx;
  logic [WORD_SIZE-1:0] load_num_inst;
  logic [WORD_SIZE-1:0] load_ans;
  logic                 start;
  logic [WORD_SIZE-1:0] num_inst;
  logic [WORD_SIZE-1:0] output_port;
  logic                 is_halted;

  logic                 done;
  logic                 all_pass;
  logic [CNT_W-1:0]     pass_count;
  logic                 fail_valid;
  logic [IDX_W-1:0]     fail_idx;
  logic [WORD_SIZE-1:0] fail_got;
  logic                 timeout;
  logic [CNT_W-1:0]     num_clock;

  modport master (
    output load_valid, load_idx, load_num_inst, load_ans, start,
           num_inst, output_port, is_halted,
    input  done, all_pass, pass_count, fail_valid, fail_idx, fail_got,
           timeout, num_clock
  );

  modport slave (
    input  load_valid, load_idx, load_num_inst, load_ans, start,
           num_inst, output_port, is_halted,
    output done, all_pass, pass_count, fail_valid, fail_idx, fail_got,
           timeout, num_clock
  );

endinterface

// File: rtl/checkpoint_table.sv
// checkpoint_table -- NUM_TEST entries of {num_inst, ans}, 2*WORD_SIZE wide.
//   clk       : write clock
//   wr_en_i   : write enable (entry wr_idx_i <= wr_data_i on rising edge)
//   wr_idx_i  : write index; indices >= NUM_TEST are dropped
//   wr_data_i : {num_inst, ans}
//   rd_idx_i  : asynchronous read index, one bit wider than wr_idx_i so the
//               "past the last entry" pointer value is representable
//   rd_data_o : entry contents, all zeros when rd_idx_i >= NUM_TEST
// Contents are never reset so a table survives a checker reset.
module checkpoint_table #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_TEST  = 56,
  parameter int IDX_W     = 6
) (
  input  logic                   clk,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [2*WORD_SIZE-1:0] wr_data_i,
  input  logic [IDX_W:0]         rd_idx_i,
  output logic [2*WORD_SIZE-1:0] rd_data_o
);

  logic [2*WORD_SIZE-1:0] mem_q [NUM_TEST];

  // Synchronous write port; an out-of-range index matches no entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TEST; i++) begin
      if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
        mem_q[i] <= wr_data_i;
      end
    end
  end

  // Asynchronous read as an AND-OR mux so out-of-range reads return zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      rd_data_o = rd_data_o | ({(2*WORD_SIZE){rd_idx_i == (IDX_W+1)'(i)}} & mem_q[i]);
    end
  end

endmodule

// File: rtl/test_checker.sv
// test_checker -- compares a processor's WWD output against a table of
// checkpoints (instruction count, expected value) while the processor runs.
//   clk, reset_n : rising-edge clock, synchronous active-low reset
//   bus (slave)  : table load, start pulse, DUT probes and sticky results
// Flow: load table in IDLE, pulse start, then in RUN each cycle examine only
// the entry at ptr. The run ends on first mismatch, halt or cycle bound,
// with priority in that order. Results are registered and held in DONE.
module test_checker
  import test_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 56,
  parameter int IDX_W      = 6,
  parameter int MAX_CYCLES = 10000,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  test_checker_if.slave bus
);

  localparam int               PTR_W     = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_END   = PTR_W'(NUM_TEST);
  localparam logic [CNT_W-1:0] PASS_ALL  = CNT_W'(NUM_TEST);
  localparam logic [CNT_W-1:0] CLK_LIMIT = CNT_W'(MAX_CYCLES - 1);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     pass_q, pass_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  result_t              res_q, res_d;
  logic [IDX_W-1:0]     fail_idx_q, fail_idx_d;
  logic [WORD_SIZE-1:0] fail_got_q, fail_got_d;

  logic [2*WORD_SIZE-1:0] entry_s;
  logic [WORD_SIZE-1:0]   entry_num_s;
  logic [WORD_SIZE-1:0]   entry_ans_s;
  logic                   table_we_s;
  logic                   entry_live_s;
  logic                   hit_s;
  logic                   hit_good_s;
  logic                   hit_bad_s;
  logic                   skip_s;
  logic [CNT_W-1:0]       clk_cnt_inc_s;

  assign table_we_s = bus.load_valid && (state_q == ST_IDLE);

  checkpoint_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_TEST  (NUM_TEST),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk       (clk),
    .wr_en_i   (table_we_s),
    .wr_idx_i  (bus.load_idx),
    .wr_data_i ({bus.load_num_inst, bus.load_ans}),
    .rd_idx_i  (ptr_q),
    .rd_data_o (entry_s)
  );

  assign entry_num_s  = entry_s[2*WORD_SIZE-1:WORD_SIZE];
  assign entry_ans_s  = entry_s[WORD_SIZE-1:0];

  // Once ptr runs past the table nothing is compared any more.
  assign entry_live_s = (ptr_q < PTR_END);
  assign hit_s        = entry_live_s && (bus.num_inst == entry_num_s);
  assign hit_good_s   = hit_s && (bus.output_port == entry_ans_s);
  assign hit_bad_s    = hit_s && (bus.output_port != entry_ans_s);
  // The DUT retired past this checkpoint without us seeing it: skip, no credit.
  assign skip_s       = entry_live_s && (bus.num_inst > entry_num_s);

  assign clk_cnt_inc_s = (clk_cnt_q == {CNT_W{1'b1}}) ? clk_cnt_q : (clk_cnt_q + CNT_W'(1));

  // Next-state and result update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pass_d     = pass_q;
    clk_cnt_d  = clk_cnt_q;
    res_d      = res_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        clk_cnt_d = clk_cnt_inc_s;
        // A pass in the halt cycle is still credited before leaving RUN.
        if (hit_good_s) begin
          pass_d = pass_q + CNT_W'(1);
          ptr_d  = ptr_q + PTR_W'(1);
        end else if (skip_s) begin
          ptr_d  = ptr_q + PTR_W'(1);
        end else begin
          ptr_d  = ptr_q;
        end
        // Termination priority: mismatch, then halt, then cycle bound.
        if (hit_bad_s) begin
          res_d.fail_valid = 1'b1;
          fail_idx_d       = ptr_q[IDX_W-1:0];
          fail_got_d       = bus.output_port;
          state_d          = ST_DONE;
        end else if (bus.is_halted) begin
          state_d          = ST_DONE;
        end else if (clk_cnt_inc_s == CLK_LIMIT) begin
          res_d.timeout    = 1'b1;
          state_d          = ST_DONE;
        end else begin
          state_d          = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    res_d.done     = (state_d == ST_DONE);
    res_d.all_pass = (state_d == ST_DONE) && (pass_d == PASS_ALL);
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      pass_q     <= '0;
      clk_cnt_q  <= '0;
      res_q      <= RESULT_CLEAR;
      fail_idx_q <= '0;
      fail_got_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pass_q     <= pass_d;
      clk_cnt_q  <= clk_cnt_d;
      res_q      <= res_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
    end
  end

  assign bus.done       = res_q.done;
  assign bus.all_pass   = res_q.all_pass;
  assign bus.pass_count = pass_q;
  assign bus.fail_valid = res_q.fail_valid;
  assign bus.fail_idx   = fail_idx_q;
  assign bus.fail_got   = fail_got_q;
  assign bus.timeout    = res_q.timeout;
  assign bus.num_clock  = clk_cnt_q;

endmodule
